// File: rtl/countdown_timer.sv
// Programmable down-counting timer with one-shot and auto-reload modes.
// Shares the clk/reset/load/le/ce interface of the load/enable up-counter.
module countdown_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] load,
  input  logic         le,
  input  logic         start,
  input  logic         ce,
  input  logic         auto,
  output logic [W-1:0] count,
  output logic         busy,
  output logic         done,
  output logic         tc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ZERO = {W{1'b0}};

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_reload;
  logic [W-1:0]   w_reload_nxt;
  logic [W-1:0]   r_count;
  logic [W-1:0]   w_count_nxt;
  logic           r_tc;
  logic           w_tc_nxt;

  // State, reload, count and strobe registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_reload <= ZERO;
      r_count  <= ZERO;
      r_tc     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_reload <= w_reload_nxt;
      r_count  <= w_count_nxt;
      r_tc     <= w_tc_nxt;
    end
  end

  // Next-state logic; priority is le > start > ce, tc defaults low.
  always_comb begin
    w_state_nxt  = r_state;
    w_reload_nxt = r_reload;
    w_count_nxt  = r_count;
    w_tc_nxt     = 1'b0;
    if (le) begin
      w_reload_nxt = load;
      w_count_nxt  = load;
      w_state_nxt  = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (r_reload != ZERO) begin
              w_count_nxt = r_reload;
              w_state_nxt = S_RUN;
            end else begin
              // A zero period expires immediately without counting.
              w_count_nxt = ZERO;
              w_state_nxt = S_DONE;
              w_tc_nxt    = 1'b1;
            end
          end else begin
            w_count_nxt = r_count;
          end
        end
        S_RUN: begin
          if (ce) begin
            if (r_count > ONE) begin
              w_count_nxt = r_count - ONE;
            end else begin
              // Terminal edge: treat count<=1 alike so 0 can never decrement.
              w_tc_nxt = 1'b1;
              if (auto) begin
                w_count_nxt = r_reload;
              end else begin
                w_count_nxt = ZERO;
                w_state_nxt = S_DONE;
              end
            end
          end else begin
            w_count_nxt = r_count;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_count_nxt = ZERO;
        end
      endcase
    end
  end

  assign count = r_count;
  assign busy  = (r_state == S_RUN);
  assign done  = (r_state == S_DONE);
  assign tc    = r_tc;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed vector table, a reset-mid-run
// sequence, and randomized stimulus against a behavioural reference model.
module tb_countdown_timer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] load = '0;
  logic         le = 1'b0;
  logic         start = 1'b0;
  logic         ce = 1'b0;
  logic         auto = 1'b0;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic         tc;

  int checks = 0;
  int failures = 0;

  countdown_timer #(.W(W)) dut (
    .clk(clk), .reset(reset), .load(load), .le(le), .start(start),
    .ce(ce), .auto(auto), .count(count), .busy(busy), .done(done), .tc(tc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rst; int le; int ld; int st; int ce; int au;
    int ec; int eb; int ed; int et;
  } vec_t;

  vec_t vecs[$];

  // Reference model: phase 0 = idle, 1 = counting, 2 = expired.
  int m_phase = 0;
  int m_reload = 0;
  int m_count = 0;
  int m_tc = 0;

  task automatic add_v(input int rst, input int l, input int ld, input int st,
                       input int c, input int au, input int ec, input int eb,
                       input int ed, input int et);
    vec_t v;
    v.rst = rst; v.le = l; v.ld = ld; v.st = st; v.ce = c; v.au = au;
    v.ec = ec; v.eb = eb; v.ed = ed; v.et = et;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_step(input int rst, input int l, input int ld, input int st,
                            input int c, input int au);
    reset = rst[0];
    le    = l[0];
    load  = ld[W-1:0];
    start = st[0];
    ce    = c[0];
    auto  = au[0];
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input int rst, input int l, input int ld, input int st,
                            input int c, input int au);
    m_tc = 0;
    if (rst != 0) begin
      m_phase = 0; m_reload = 0; m_count = 0;
    end else if (l != 0) begin
      m_reload = ld; m_count = ld; m_phase = 0;
    end else if (m_phase != 1 && st != 0) begin
      if (m_reload == 0) begin
        m_phase = 2; m_count = 0; m_tc = 1;
      end else begin
        m_phase = 1; m_count = m_reload;
      end
    end else if (m_phase == 1 && c != 0) begin
      if (m_count == 1) begin
        m_tc = 1;
        if (au != 0) m_count = m_reload;
        else begin
          m_count = 0; m_phase = 2;
        end
      end else begin
        m_count = m_count - 1;
      end
    end
  endtask

  initial begin
    // Reset for three cycles, then load 13 and tick without start.
    for (int i = 0; i < 3; i++) add_v(1,0,0,0,0,0, 0,0,0,0);
    add_v(0,1,13,0,0,0, 13,0,0,0);
    for (int i = 0; i < 5; i++) add_v(0,0,0,0,1,0, 13,0,0,0);
    // One-shot of 3.
    add_v(0,1,3,0,0,0, 3,0,0,0);
    add_v(0,0,0,1,0,0, 3,1,0,0);
    add_v(0,0,0,0,1,0, 2,1,0,0);
    add_v(0,0,0,0,1,0, 1,1,0,0);
    add_v(0,0,0,0,1,0, 0,0,1,1);
    add_v(0,0,0,0,1,0, 0,0,1,0);
    add_v(0,0,0,0,1,0, 0,0,1,0);
    // Re-arm from DONE.
    add_v(0,0,0,1,0,0, 3,1,0,0);
    // Auto-reload of 4 (le aborts the run above, no tc).
    add_v(0,1,4,0,0,1, 4,0,0,0);
    add_v(0,0,0,1,0,1, 4,1,0,0);
    for (int k = 0; k < 3; k++) begin
      add_v(0,0,0,0,1,1, 3,1,0,0);
      add_v(0,0,0,0,1,1, 2,1,0,0);
      add_v(0,0,0,0,1,1, 1,1,0,0);
      add_v(0,0,0,0,1,1, 4,1,0,1);
    end
    // Gated ce and abort by le.
    add_v(0,1,5,0,0,0, 5,0,0,0);
    add_v(0,0,0,1,0,0, 5,1,0,0);
    add_v(0,0,0,0,1,0, 4,1,0,0);
    add_v(0,0,0,1,0,0, 4,1,0,0);
    add_v(0,0,0,0,1,0, 3,1,0,0);
    add_v(0,0,0,0,0,0, 3,1,0,0);
    add_v(0,1,2,0,1,0, 2,0,0,0);
    // Zero period expires immediately.
    add_v(0,1,0,0,0,0, 0,0,0,0);
    add_v(0,0,0,1,0,0, 0,0,1,1);
    add_v(0,0,0,0,1,0, 0,0,1,0);
    // Period of one with auto: tc every cycle.
    add_v(0,1,1,0,0,1, 1,0,0,0);
    add_v(0,0,0,1,0,1, 1,1,0,0);
    for (int i = 0; i < 3; i++) add_v(0,0,0,0,1,1, 1,1,0,1);
    // le and start together: le wins.
    add_v(0,1,7,1,1,0, 7,0,0,0);
    add_v(0,0,0,0,1,0, 7,0,0,0);
    // All-ones period loads and arms.
    add_v(0,1,255,0,0,0, 255,0,0,0);
    add_v(0,0,0,1,0,0, 255,1,0,0);
    add_v(0,0,0,0,1,0, 254,1,0,0);

    foreach (vecs[i]) begin
      drive_step(vecs[i].rst, vecs[i].le, vecs[i].ld, vecs[i].st, vecs[i].ce, vecs[i].au);
      chk($sformatf("vec%0d.count", i), int'(count), vecs[i].ec);
      chk($sformatf("vec%0d.busy", i), int'(busy), vecs[i].eb);
      chk($sformatf("vec%0d.done", i), int'(done), vecs[i].ed);
      chk($sformatf("vec%0d.tc", i), int'(tc), vecs[i].et);
    end

    // Reset in the middle of a long run.
    drive_step(0,1,200,0,0,0);
    drive_step(0,0,0,1,0,0);
    for (int i = 0; i < 10; i++) drive_step(0,0,0,0,1,0);
    chk("midrun.count", int'(count), 190);
    chk("midrun.busy", int'(busy), 1);
    drive_step(1,0,0,0,1,0);
    chk("rst_midrun.count", int'(count), 0);
    chk("rst_midrun.busy", int'(busy), 0);
    chk("rst_midrun.done", int'(done), 0);
    chk("rst_midrun.tc", int'(tc), 0);

    // Randomized stimulus against the reference model.
    model_step(1,0,0,0,0,0);
    for (int i = 0; i < 3000; i++) begin
      int r_rst, r_le, r_ld, r_st, r_ce, r_au;
      r_rst = ($urandom_range(0, 199) == 0) ? 1 : 0;
      r_le  = ($urandom_range(0, 24) == 0) ? 1 : 0;
      r_ld  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                           : int'($urandom_range(0, 6));
      r_st  = ($urandom_range(0, 5) == 0) ? 1 : 0;
      r_ce  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      r_au  = int'($urandom_range(0, 1));
      drive_step(r_rst, r_le, r_ld, r_st, r_ce, r_au);
      model_step(r_rst, r_le, r_ld, r_st, r_ce, r_au);
      chk($sformatf("rnd%0d.count", i), int'(count), m_count);
      chk($sformatf("rnd%0d.busy", i), int'(busy), (m_phase == 1) ? 1 : 0);
      chk($sformatf("rnd%0d.done", i), int'(done), (m_phase == 2) ? 1 : 0);
      chk($sformatf("rnd%0d.tc", i), int'(tc), m_tc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
